laser_packet_framer: RTL and testbench

Transmit-side packet framer for the laser link, the sending counterpart of the receive-side sequence detection and FTDI write path. It pops bytes from the FTDI read queue and feeds them byte-by-byte to the laser transmitter as packets. Each packet is a 4-byte header (START or DATA), up to `PKT_LEN` payload bytes, and an ACK wait. A session ends with a 4-byte STOP packet once the read queue drains. It sits between `FTDI_Interface` (read side) and `LaserTransmitter`, and takes `saw_ack` from `SequenceDetector`.

---
 rtl/laser_packet_framer.sv | 171 +++++++++++++++++
 tb/tb_laser_packet_framer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_packet_framer.sv
// laser_packet_framer: pops FTDI read-queue bytes and frames them as START/DATA/STOP packets
// for the laser transmitter, waiting for an ACK after every START/DATA packet.
module laser_packet_framer #(
    parameter int PKT_LEN     = 1024,
    parameter int IDLE_GAP    = 64,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        rdq_empty,
    input  logic [7:0]  data_rd,
    output logic        rdreq,
    input  logic        tx_done,
    output logic        data_ready,
    output logic [7:0]  data_transmit,
    input  logic        saw_ack,
    output logic        busy,
    output logic        pkt_sent,
    output logic        ack_fail,
    output logic [15:0] pkt_count
);
    localparam int CW = $clog2(PKT_LEN + 1);
    localparam int GW = $clog2(IDLE_GAP + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] PL_MAX  = CW'(PKT_LEN);
    localparam logic [GW-1:0] GAP_MAX = GW'(IDLE_GAP);
    localparam logic [TW-1:0] TMO     = TW'(ACK_TIMEOUT);
    localparam logic [31:0] START = 32'hc1c2c3c4;
    localparam logic [31:0] DATA  = 32'hd1d2d3d4;
    localparam logic [31:0] STOP  = 32'h51525354;

    typedef enum logic [3:0] {
        IDLE, HDR_SEND, HDR_GAP, FETCH, LOAD, PL_SEND, PL_GAP, WAIT_ACK, STOP_SEND, STOP_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          first_q, first_d;
    logic [7:0]    byte_q, byte_d;
    logic [15:0]   pcnt_q, pcnt_d;
    logic          sent_q, sent_d;
    logic          fail_q, fail_d;
    logic [31:0]   hdr_w;

    // Header bytes go out MSB byte first: index 0 selects bits 31:24.
    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
        return w[{~i, 3'b000} +: 8];
    endfunction

    assign hdr_w = first_q ? START : DATA;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        tmr_d   = '0;
        first_d = first_q;
        byte_d  = byte_q;
        pcnt_d  = pcnt_q;
        sent_d  = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                gap_d = '0;
                if (en && !rdq_empty) begin
                    state_d = HDR_SEND;
                    byte_d  = pick(hdr_w, 2'd0);
                end
            end
            HDR_SEND: if (!tx_done) begin
                state_d = HDR_GAP;
                if (idx_q == 2'd3) first_d = 1'b0;
            end
            HDR_GAP: if (tx_done) begin
                if (idx_q == 2'd3) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    gap_d   = '0;
                end else begin
                    state_d = HDR_SEND;
                    idx_d   = idx_q + 2'd1;
                    byte_d  = pick(hdr_w, idx_q + 2'd1);
                end
            end
            FETCH: if (!rdq_empty) begin
                state_d = LOAD;
                gap_d   = '0;
            end else begin
                gap_d = gap_q + 1'b1;
                if (gap_d == GAP_MAX) state_d = WAIT_ACK;
            end
            LOAD: begin
                byte_d  = data_rd;
                cnt_d   = cnt_q + 1'b1;
                state_d = PL_SEND;
            end
            PL_SEND: if (!tx_done) state_d = PL_GAP;
            PL_GAP: if (tx_done) state_d = (cnt_q == PL_MAX) ? WAIT_ACK : FETCH;
            WAIT_ACK: begin
                tmr_d = tmr_q + 1'b1;
                // An ACK arriving on the timeout cycle still counts as delivered.
                if (saw_ack) begin
                    sent_d  = 1'b1;
                    pcnt_d  = pcnt_q + 16'd1;
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = rdq_empty ? STOP_SEND : HDR_SEND;
                    byte_d  = rdq_empty ? pick(STOP, 2'd0) : pick(hdr_w, 2'd0);
                end else if (tmr_d == TMO) begin
                    fail_d  = 1'b1;
                    first_d = 1'b1;
                    state_d = IDLE;
                end
            end
            STOP_SEND: if (!tx_done) state_d = STOP_GAP;
            STOP_GAP: if (tx_done) begin
                if (idx_q == 2'd3) begin
                    first_d = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    state_d = STOP_SEND;
                    idx_d   = idx_q + 2'd1;
                    byte_d  = pick(STOP, idx_q + 2'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            tmr_q   <= '0;
            first_q <= 1'b1;
            byte_q  <= '0;
            pcnt_q  <= '0;
            sent_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            tmr_q   <= tmr_d;
            first_q <= first_d;
            byte_q  <= byte_d;
            pcnt_q  <= pcnt_d;
            sent_q  <= sent_d;
            fail_q  <= fail_d;
        end
    end

    assign busy          = state_q != IDLE;
    assign data_ready    = state_q inside {HDR_SEND, PL_SEND, STOP_SEND};
    assign rdreq         = (state_q == FETCH) && !rdq_empty;
    assign data_transmit = byte_q;
    assign pkt_count     = pcnt_q;
    assign pkt_sent      = sent_q;
    assign ack_fail      = fail_q;
endmodule

// File: tb/tb_laser_packet_framer.sv
// tb_laser_packet_framer: queue + transmitter models with a byte scoreboard around laser_packet_framer
// (PKT_LEN=8, IDLE_GAP=16, ACK_TIMEOUT=32).
module tb_laser_packet_framer;
    logic        clock = 1'b0, reset = 1'b1, en = 1'b0, rdq_empty = 1'b1, tx_done = 1'b1, saw_ack = 1'b0;
    logic [7:0]  data_rd = 8'h00;
    logic        rdreq, data_ready, busy, pkt_sent, ack_fail;
    logic [7:0]  data_transmit;
    logic [15:0] pkt_count;
    int          checks = 0, errors = 0, got_n = 0, sent_n = 0, fail_n = 0, tx_delay = 16;
    logic [7:0]  fifo[$];
    logic [7:0]  exp_q[$];
    logic        rd_pend, stable;
    logic [7:0]  mb, me;

    always #5 clock = ~clock;

    laser_packet_framer #(.PKT_LEN(8), .IDLE_GAP(16), .ACK_TIMEOUT(32)) dut (
        .clock(clock), .reset(reset), .en(en), .rdq_empty(rdq_empty), .data_rd(data_rd),
        .rdreq(rdreq), .tx_done(tx_done), .data_ready(data_ready), .data_transmit(data_transmit),
        .saw_ack(saw_ack), .busy(busy), .pkt_sent(pkt_sent), .ack_fail(ack_fail), .pkt_count(pkt_count)
    );

    // FTDI read queue: head changes the cycle after rdreq and holds until the next pop.
    initial forever begin
        @(negedge clock);
        rd_pend = rdreq;
        @(posedge clock);
        #1;
        if (rd_pend && fifo.size() > 0) data_rd = fifo.pop_front();
        rdq_empty = (fifo.size() == 0);
    end

    // Transmitter: waits tx_delay cycles with tx_done=1, accepts, then stays busy for 3 cycles.
    initial forever begin
        @(posedge clock);
        #1;
        if (data_ready && tx_done && !reset) begin
            mb = data_transmit;
            stable = 1'b1;
            repeat (tx_delay) begin
                @(posedge clock);
                #1;
                if (!data_ready || data_transmit !== mb) stable = 1'b0;
            end
            tx_done = 1'b0;
            @(posedge clock);
            #1;
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL hold_stable: byte %h changed to %h / ready %b before accept", mb, data_transmit, data_ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_byte: got %h, expected no byte", mb);
            end else begin
                me = exp_q.pop_front();
                if (mb !== me) begin
                    errors++;
                    $display("FAIL tx_byte[%0d]: got %h, expected %h", got_n, mb, me);
                end
            end
            got_n++;
            repeat (2) begin
                @(posedge clock);
                #1;
            end
            tx_done = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (pkt_sent) sent_n++;
        if (ack_fail) fail_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic exp_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[31-8*i -: 8]);
    endtask

    task automatic wait_bytes(input int n);
        int tgt, k;
        tgt = got_n + n;
        k = 0;
        while (got_n < tgt && k < 3000) begin
            @(posedge clock);
            #2;
            k++;
        end
        checks++;
        if (got_n < tgt) begin
            errors++;
            $display("FAIL byte_timeout: got %0d bytes, required %0d", got_n, tgt);
        end
    endtask

    task automatic ack_after(input int m);
        repeat (m) @(posedge clock);
        #1 saw_ack = 1'b1;
        @(posedge clock);
        #1 saw_ack = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 500) begin
            @(posedge clock);
            #2;
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy %b, required 0", busy);
        end
    endtask

    task automatic check_end(input string name, input int sent0, input int sent_exp, input logic [15:0] cnt_exp);
        checks++;
        if (pkt_count !== cnt_exp || sent_n - sent0 != sent_exp || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: pkt_count %0d sent %0d left %0d, required %0d %0d 0",
                     name, pkt_count, sent_n - sent0, exp_q.size(), cnt_exp, sent_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({rdreq, data_ready, data_transmit, busy, pkt_sent, ack_fail, pkt_count} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required all 0",
                     {rdreq, data_ready, data_transmit, busy, pkt_sent, ack_fail, pkt_count});
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int s0;
        s0 = sent_n;
        en = 1'b0;
        tx_delay = 16;
        fifo.push_back(8'h11); fifo.push_back(8'h22); fifo.push_back(8'h33);
        exp_word(32'hc1c2c3c4);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        exp_word(32'h51525354);
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL en_gate: busy %b with en=0, required 0", busy);
        end
        en = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({data_ready, data_transmit} !== {1'b1, 8'hc1}) begin
            errors++;
            $display("FAIL start_timing: ready %b byte %h, required 1 c1", data_ready, data_transmit);
        end
        wait_bytes(7);
        ack_after(30);
        wait_bytes(4);
        wait_idle();
        check_end("single", s0, 1, 16'd1);
    endtask

    task automatic test_split();
        int s0;
        s0 = sent_n;
        exp_word(32'hc1c2c3c4);
        for (int i = 0; i < 9; i++) begin
            fifo.push_back(8'(8'h40 + i));
            if (i == 8) exp_word(32'hd1d2d3d4);
            exp_q.push_back(8'(8'h40 + i));
        end
        exp_word(32'h51525354);
        wait_bytes(12);
        ack_after(10);
        wait_bytes(5);
        ack_after(30);
        wait_bytes(4);
        wait_idle();
        check_end("split", s0, 2, 16'd3);
    endtask

    task automatic test_held();
        int s0;
        s0 = sent_n;
        tx_delay = 5;
        fifo.push_back(8'h3c); fifo.push_back(8'hc3);
        exp_word(32'hc1c2c3c4);
        exp_q.push_back(8'h3c); exp_q.push_back(8'hc3);
        exp_word(32'h51525354);
        wait_bytes(6);
        ack_after(30);
        wait_bytes(4);
        wait_idle();
        check_end("held", s0, 1, 16'd4);
    endtask

    task automatic test_timeout();
        int s0, f0;
        s0 = sent_n;
        f0 = fail_n;
        fifo.push_back(8'h5a);
        exp_word(32'hc1c2c3c4);
        exp_q.push_back(8'h5a);
        wait_bytes(5);
        repeat (50) @(posedge clock);
        #1;
        checks++;
        if ({ack_fail, busy} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_early: ack_fail %b busy %b, required 0 1", ack_fail, busy);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({ack_fail, busy} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_edge: ack_fail %b busy %b, required 1 0", ack_fail, busy);
        end
        fifo.push_back(8'ha5);
        exp_word(32'hc1c2c3c4);
        exp_q.push_back(8'ha5);
        exp_word(32'h51525354);
        wait_bytes(5);
        ack_after(30);
        wait_bytes(4);
        wait_idle();
        checks++;
        if (fail_n - f0 != 1) begin
            errors++;
            $display("FAIL timeout_count: ack_fail pulses %0d, required 1", fail_n - f0);
        end
        check_end("timeout", s0, 1, 16'd5);
    endtask

    task automatic test_tie();
        int s0, f0;
        s0 = sent_n;
        f0 = fail_n;
        fifo.push_back(8'h77);
        exp_word(32'hc1c2c3c4);
        exp_q.push_back(8'h77);
        exp_word(32'h51525354);
        wait_bytes(5);
        ack_after(50);
        checks++;
        if ({pkt_sent, ack_fail} !== 2'b10) begin
            errors++;
            $display("FAIL ack_tie: pkt_sent %b ack_fail %b, required 1 0", pkt_sent, ack_fail);
        end
        wait_bytes(4);
        wait_idle();
        checks++;
        if (fail_n != f0) begin
            errors++;
            $display("FAIL tie_fail_count: ack_fail pulses %0d, required 0", fail_n - f0);
        end
        check_end("tie", s0, 1, 16'd6);
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = sent_n;
        for (int i = 1; i <= 5; i++) fifo.push_back(8'(i));
        exp_word(32'hc1c2c3c4);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        wait_bytes(6);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({rdreq, data_ready, data_transmit, busy, pkt_sent, ack_fail, pkt_count} !== 29'd0) begin
            errors++;
            $display("FAIL reset_mid: got %b, required all 0",
                     {rdreq, data_ready, data_transmit, busy, pkt_sent, ack_fail, pkt_count});
        end
        reset = 1'b0;
        exp_word(32'hc1c2c3c4);
        exp_q.push_back(8'h03); exp_q.push_back(8'h04); exp_q.push_back(8'h05);
        exp_word(32'h51525354);
        wait_bytes(7);
        ack_after(30);
        wait_bytes(4);
        wait_idle();
        check_end("reset_mid", s0, 1, 16'd1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_held();
        test_timeout();
        test_tie();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
